hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 18 +
 rtl/hazard_scoreboard_if.sv | 35 +++
 rtl/hazard_scoreboard_mask.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 119 +++++++++++
 tb/tb_hazard_scoreboard.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared pipeline definitions for the hazard scoreboard.
//   REG_ADDR_W / NUM_REGS : register-file addressing constants
//   sb_state_e            : occupancy state encoding (IDLE / BUSY / FULL)
//   reg_addr_t            : register address type
package hazard_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } sb_state_e;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode/writeback handshake bundle for the scoreboard.
//   issue_*  : instruction presented by decode (valid, sources, destination, kind)
//   wb_*     : one retiring instruction from writeback
//   flush    : discard all in-flight instructions
//   stall    : decode must hold the presented instruction
// Modports: master = pipeline side, slave = scoreboard side.
interface hazard_scoreboard_if;
    import hazard_scoreboard_pkg::*;

    logic      issue_valid;
    reg_addr_t issue_rs1;
    reg_addr_t issue_rs2;
    logic      issue_use_rs1;
    logic      issue_use_rs2;
    reg_addr_t issue_rd;
    logic      issue_rd_we;
    logic      issue_is_load;
    logic      wb_valid;
    reg_addr_t wb_rd;
    logic      flush;
    logic      stall;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
        output issue_rd, issue_rd_we, issue_is_load, wb_valid, wb_rd, flush,
        input  stall
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
        input  issue_rd, issue_rd_we, issue_is_load, wb_valid, wb_rd, flush,
        output stall
    );

endinterface

// File: rtl/hazard_scoreboard_mask.sv
// scoreboard_mask: NUM_REGS-bit per-register flag register.
//   clk, rst         : clock, asynchronous active-high reset
//   flush            : clear every bit at the next edge (overrides all)
//   wr_en/idx/val    : write one bit to wr_val; wins over a same-index clear
//   clr_en/clr_idx   : clear one bit
//   mask             : registered flags; bit 0 (x0) is never set
module scoreboard_mask
    import hazard_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wr_en,
    input  reg_addr_t           wr_idx,
    input  logic                wr_val,
    input  logic                clr_en,
    input  reg_addr_t           clr_idx,
    output logic [NUM_REGS-1:0] mask
);

    logic [NUM_REGS-1:0] mask_d;

    always_comb begin
        mask_d = mask;
        if (clr_en)
            mask_d[clr_idx] = 1'b0;
        if (wr_en)
            mask_d[wr_idx] = wr_val;
        mask_d[0] = 1'b0;
        if (flush)
            mask_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mask <= '0;
        else
            mask <= mask_d;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks outstanding register writes and stalls decode on
// load-use hazards or when MAX_INFLIGHT instructions are outstanding.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : hazard_scoreboard_if.slave (issue / writeback / flush / stall)
//   pending_mask : registers with an outstanding write
//   load_mask    : subset of pending_mask produced by loads
//   inflight     : outstanding-instruction count
//   wb_err       : sticky, set by a retire with nothing in flight
//   stall_cycles : saturating stall-cycle count when HAZARD_SCOREBOARD_STATS_EN
//                  is defined, otherwise constant 0
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 3
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [NUM_REGS-1:0] load_mask,
    output logic [2:0]          inflight,
    output logic                wb_err,
    output logic [31:0]         stall_cycles
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

    sb_state_e  state_q, state_d;
    logic [2:0] inflight_d;
    logic       stall, load_use, at_limit;
    logic       accept, retire, rd_write;

    always_comb begin
        load_use = (bus.issue_use_rs1 && (bus.issue_rs1 != '0) && load_mask[bus.issue_rs1]) ||
                   (bus.issue_use_rs2 && (bus.issue_rs2 != '0) && load_mask[bus.issue_rs2]);
        // A same-cycle retire frees a slot, so a full scoreboard still accepts.
        at_limit = (state_q == FULL) && !bus.wb_valid;
        stall    = bus.issue_valid && !bus.flush && (load_use || at_limit);
        accept   = bus.issue_valid && !stall && !bus.flush;
        retire   = bus.wb_valid && (inflight != '0) && !bus.flush;
        rd_write = accept && bus.issue_rd_we && (bus.issue_rd != '0);
    end

    assign bus.stall = stall;

    always_comb begin
        state_d    = state_q;
        inflight_d = inflight;
        if (bus.flush) begin
            state_d    = IDLE;
            inflight_d = '0;
        end else if (accept && !retire) begin
            inflight_d = inflight + 3'd1;
            unique case (state_q)
                IDLE:    state_d = (MAX_INFLIGHT == 1) ? FULL : BUSY;
                BUSY:    if (inflight == MAX_CNT - 3'd1) state_d = FULL;
                default: state_d = state_q;
            endcase
        end else if (retire && !accept) begin
            inflight_d = inflight - 3'd1;
            unique case (state_q)
                FULL:    state_d = (MAX_INFLIGHT == 1) ? IDLE : BUSY;
                BUSY:    if (inflight == 3'd1) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            inflight <= '0;
            wb_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            inflight <= inflight_d;
            if (bus.wb_valid && (inflight == '0) && !accept)
                wb_err <= 1'b1;
        end
    end

    scoreboard_mask u_pending (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .wr_en   (rd_write),
        .wr_idx  (bus.issue_rd),
        .wr_val  (1'b1),
        .clr_en  (retire),
        .clr_idx (bus.wb_rd),
        .mask    (pending_mask)
    );

    // A non-load producer overwrites the bit with 0, so a newer ALU write to a
    // register hides an older outstanding load to it.
    scoreboard_mask u_load (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .wr_en   (rd_write),
        .wr_idx  (bus.issue_rd),
        .wr_val  (bus.issue_is_load),
        .clr_en  (retire),
        .clr_idx (bus.wb_rd),
        .mask    (load_mask)
    );

`ifdef HAZARD_SCOREBOARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic for
// hazard_scoreboard, checked every cycle against a behavioural register model.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int unsigned MAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if bus();

    logic [31:0] pending_mask, load_mask, stall_cycles;
    logic [2:0]  inflight;
    logic        wb_err;

    hazard_scoreboard #(.MAX_INFLIGHT(MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .pending_mask (pending_mask),
        .load_mask    (load_mask),
        .inflight     (inflight),
        .wb_err       (wb_err),
        .stall_cycles (stall_cycles)
    );

    // Behavioural model state
    bit [31:0]       m_pend = '0;
    bit [31:0]       m_ld   = '0;
    int unsigned     m_cnt  = 0;
    bit              m_err  = 1'b0;
    longint unsigned m_stc  = 0;

    int n_cmp  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_stall();
        bit hz;
        if (!bus.issue_valid || bus.flush)
            return 1'b0;
        hz = (bus.issue_use_rs1 && bus.issue_rs1 != 0 && m_ld[bus.issue_rs1]) ||
             (bus.issue_use_rs2 && bus.issue_rs2 != 0 && m_ld[bus.issue_rs2]);
        return hz || (m_cnt == MAX && !bus.wb_valid);
    endfunction

    // Model update at each edge from the rules of the scoreboard.
    always @(posedge clk or posedge rst) begin : model
        bit st, acc, ret;
        if (rst) begin
            m_pend = '0; m_ld = '0; m_cnt = 0; m_err = 1'b0; m_stc = 0;
        end else begin
            st  = m_stall();
            acc = bus.issue_valid && !st && !bus.flush;
            ret = bus.wb_valid && m_cnt != 0;
            if (st && m_stc < 64'hFFFF_FFFF)
                m_stc++;
            if (bus.wb_valid && m_cnt == 0 && !acc)
                m_err = 1'b1;
            if (bus.flush) begin
                m_pend = '0; m_ld = '0; m_cnt = 0;
            end else begin
                if (ret) begin
                    m_pend[bus.wb_rd] = 1'b0;
                    m_ld[bus.wb_rd]   = 1'b0;
                    m_cnt--;
                end
                if (acc) begin
                    m_cnt++;
                    if (bus.issue_rd_we && bus.issue_rd != 0) begin
                        m_pend[bus.issue_rd] = 1'b1;
                        m_ld[bus.issue_rd]   = bus.issue_is_load;
                    end
                end
            end
        end
    end

    // Per-cycle compare, well away from the rising edge.
    always @(negedge clk) begin
        #3;
        if (chk_en) begin
            check("stall", 32'(bus.stall), 32'(m_stall()));
            check("pending_mask", pending_mask, m_pend);
            check("load_mask", load_mask, m_ld);
            check("inflight", 32'(inflight), m_cnt);
            check("wb_err", 32'(wb_err), 32'(m_err));
`ifdef HAZARD_SCOREBOARD_STATS_EN
            check("stall_cycles", stall_cycles, m_stc[31:0]);
`else
            check("stall_cycles", stall_cycles, 32'd0);
`endif
        end
    end

    task automatic drive(input bit iv, input logic [4:0] rd, input bit we, input bit ld,
                         input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                         input bit wv, input logic [4:0] wrd, input bit fl);
        bus.issue_valid   = iv;
        bus.issue_rd      = rd;
        bus.issue_rd_we   = we;
        bus.issue_is_load = ld;
        bus.issue_rs1     = rs1;
        bus.issue_use_rs1 = u1;
        bus.issue_rs2     = rs2;
        bus.issue_use_rs2 = u2;
        bus.wb_valid      = wv;
        bus.wb_rd         = wrd;
        bus.flush         = fl;
    endtask

    // Drive one cycle at the falling edge; returns just before the rising edge.
    task automatic tick(input bit iv, input logic [4:0] rd, input bit we, input bit ld,
                        input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                        input bit wv, input logic [4:0] wrd, input bit fl);
        @(negedge clk);
        drive(iv, rd, we, ld, rs1, u1, rs2, u2, wv, wrd, fl);
        #4;
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_flush();
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_pending", pending_mask, 32'd0);
        check("rst_load", load_mask, 32'd0);
        check("rst_inflight", 32'(inflight), 32'd0);
        check("rst_wb_err", 32'(wb_err), 32'd0);
        check("rst_stall_cycles", stall_cycles, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        idle();
        check("reset_pending", pending_mask, 32'd0);
        check("reset_inflight", 32'(inflight), 32'd0);
        check("reset_wb_err", 32'(wb_err), 32'd0);
        check("reset_stall", 32'(bus.stall), 32'd0);

        // Load-use stall and unblock after writeback of x5
        tick(1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        check("loaduse_stall", 32'(bus.stall), 32'd1);
        tick(1, 0, 0, 0, 5, 1, 0, 0, 1, 5, 0);
        check("loaduse_stall_during_wb", 32'(bus.stall), 32'd1);
        tick(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        check("loaduse_unblocked", 32'(bus.stall), 32'd0);
        check("loaduse_ld5_clear", 32'(load_mask[5]), 32'd0);
        do_flush();

        // ALU producer forwards, no stall
        tick(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        check("alu_no_stall", 32'(bus.stall), 32'd0);
        check("alu_pend6", 32'(pending_mask[6]), 32'd1);
        check("alu_ld6", 32'(load_mask[6]), 32'd0);
        do_flush();

        // In-flight limit
        tick(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("limit_inflight", 32'(inflight), 32'd3);
        check("limit_stall", 32'(bus.stall), 32'd1);
        tick(1, 4, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        check("limit_stall_with_wb", 32'(bus.stall), 32'd0);
        idle();
        check("limit_inflight_kept", 32'(inflight), 32'd3);
        do_flush();

        // Same-cycle set and clear of x7: set wins
        tick(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 7, 1, 0, 0, 0, 0, 0, 1, 7, 0);
        idle();
        check("setclr_pend7", 32'(pending_mask[7]), 32'd1);
        check("setclr_inflight", 32'(inflight), 32'd1);

        // Flush with two in flight overrides a same-cycle accept and retire
        tick(1, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        check("flush_pre_inflight", 32'(inflight), 32'd2);
        check("flush_pre_pend", pending_mask, 32'h0000_0180);
        check("flush_pre_ld", load_mask, 32'h0000_0100);
        tick(1, 9, 1, 0, 0, 0, 0, 0, 1, 7, 1);
        check("flush_stall", 32'(bus.stall), 32'd0);
        idle();
        check("flush_pend", pending_mask, 32'd0);
        check("flush_ld", load_mask, 32'd0);
        check("flush_inflight", 32'(inflight), 32'd0);

        // Mid-operation asynchronous reset
        tick(1, 10, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        async_reset();

        // Stall statistics: four load-use stall cycles
        tick(1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        idle();
        check("stats_inflight", 32'(inflight), 32'd1);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        check("stats_four", stall_cycles, 32'd4);
`else
        check("stats_tied", stall_cycles, 32'd0);
`endif

        // Spurious retire sets a sticky error that survives flush
        tick(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        check("spurious_no_err_yet", 32'(wb_err), 32'd0);
        do_flush();
        check("spurious_err", 32'(wb_err), 32'd1);
        idle();
        check("spurious_err_after_flush", 32'(wb_err), 32'd1);
        check("spurious_inflight", 32'(inflight), 32'd0);

        // Randomized traffic on a small register window to provoke hazards
        async_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                tick($urandom_range(0, 9) < 7,
                     5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                     5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)),
                     $urandom_range(0, 24) == 0);
            end
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
